ysyx_22040759_ifu_axi_bridge: RTL and testbench
===============================================

// Module: ysyx_22040759_ifu_axi_bridge
// PURPOSE
//  Responder end of the IF fetch handshake (if_valid/inst_addr -> if_ready/if_data_read).
//  Each accepted fetch becomes one single-beat AXI4 read of 64 bits.
//  It keeps a one-entry 64-bit line buffer, so the other word of the same doubleword returns without AXI traffic.
//  Sits between the IF stage and the AXI read master port of the core.
// PARAMETERS
//  AXI_ADDR_W  32      AXI address width; inst_addr bits above it are ignored
//  AXI_ID      4'd0    constant arid; responses with another rid are protocol errors
//  LBUF_EN     1       1 = line buffer enabled; 0 = every fetch goes to AXI
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous reset, active-low
//  if_valid       in   1           fetch request; held high with inst_addr stable until if_ready
//  inst_addr      in   64          fetch byte address
//  if_ready       out  1           one-cycle pulse: response valid this cycle
//  if_data_read   out  64          {32'h0, instruction word}
//  if_resp_err    out  1           valid with if_ready: misaligned fetch or AXI error
//  fence_i        in   1           invalidate the line buffer
//  arvalid        out  1           AXI read address valid
//  arready        in   1           AXI read address ready
//  araddr         out  AXI_ADDR_W  {inst_addr[AXI_ADDR_W-1:3], 3'b0}
//  arid           out  4           AXI_ID
//  arlen          out  8           8'd0 (single beat)
//  arsize         out  3           3'b011 (8 bytes)
//  arburst        out  2           2'b01 (INCR)
//  rvalid         in   1           AXI read data valid
//  rready         out  1           AXI read data ready
//  rdata          in   64          AXI read data
//  rresp          in   2           AXI read response
//  rlast          in   1           AXI last beat
//  rid            in   4           AXI read id
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State goes to IDLE; line buffer is invalid.
//   - arvalid=0, rready=0, if_ready=0, if_resp_err=0, if_data_read=0.
//   - An in-flight AXI read is abandoned; the interconnect is reset by the same rst_n.
//  IDLE
//   - On if_valid with inst_addr[1:0]!=0: go to RESP with err=1, data=32'h13. No AXI access.
//   - Else if LBUF_EN, buffer valid, tag==inst_addr[AXI_ADDR_W-1:3] and fence_i=0 (hit):
//     go to RESP with data=buf word and err=0.
//   - Else (miss): latch the address and go to AR.
//  AR
//   - arvalid=1 and araddr are held stable until arready.
//   - arvalid must not drop before the handshake; on arvalid&arready go to R.
//  R
//   - rready=1.
//   - Accept the beat on rvalid&rready&rlast. rlast=0 or rid!=AXI_ID is a protocol error: it flags err and the beat is not allocated.
//   - rresp!=2'b00: err=1, data=rdata word, buffer stays invalid.
//   - Otherwise the buffer stores rdata, the tag and valid=1.
//   - Then go to RESP.
//  RESP
//   - if_ready=1 for exactly one cycle, with if_data_read and if_resp_err; then go to IDLE.
//   - If if_valid=0 in this cycle, the response is dropped silently; the buffer fill still stands.
//  Word select: instruction = addr[2] ? dword[63:32] : dword[31:0]. if_data_read[63:32]=0.
//  Outputs if_data_read/if_resp_err are registered, and hold their value outside RESP.
//  Latency (T = cycle if_valid is first sampled in IDLE)
//   - hit: if_ready at T+1.
//   - miss with arready and rvalid at first opportunity: arvalid at T+1, R beat at T+2, if_ready at T+3.
//  At most one outstanding AXI read; a new request is not sampled until back in IDLE.
//  fence_i
//   - In any state it clears buffer valid that cycle.
//   - If asserted while in AR or R, the pending beat is returned to IF but not allocated.
//   - fence_i in the same IDLE cycle as a request forces a miss.
//  Hit and refill to the same tag never happen in the same cycle (single outstanding read).
// TESTING
//  1 Reset release, if_valid, addr 0x80000000, arready=1, rvalid next cycle, rdata=0x00000297_00100073
//    -> araddr=0x80000000, if_ready at T+3, data=0x00100073, err=0.
//  2 Next fetch 0x80000004 -> no arvalid, if_ready at T+1, data=0x00000297.
//  3 Fetch 0x80000004, fence_i pulse, fetch 0x80000004 again -> second fetch misses, arvalid asserted.
//  4 arready held low 5 cycles -> arvalid/araddr stable throughout, single AR handshake, response correct.
//  5 rresp=2'b10 on 0x80000010 -> if_resp_err=1; refetch 0x80000014 misses (buffer not filled).
//  6 Misaligned 0x80000002 -> if_ready at T+1, err=1, data=0x13, no AXI.
//    Then assert rst_n=0 while in R -> all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_22040759_ifu_axi_bridge.sv
`timescale 1ns/1ps
// IF-side fetch responder: turns each accepted fetch into one 64-bit AXI4 read
// and keeps the last doubleword in a one-entry line buffer for the sibling word.
module ysyx_22040759_ifu_axi_bridge #(
  parameter int         AXI_ADDR_W = 32,
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter bit         LBUF_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [63:0]           inst_addr,
  output logic                  if_ready,
  output logic [63:0]           if_data_read,
  output logic                  if_resp_err,
  input  logic                  fence_i,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [3:0]            arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [63:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [3:0]            rid,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; a valid, once raised, holds its payload until that edge.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam int         TAG_W  = AXI_ADDR_W - 3;

  logic [1:0]            state;
  logic [AXI_ADDR_W-1:2] addr_q;
  logic                  buf_valid;
  logic [TAG_W-1:0]      buf_tag;
  logic [63:0]           buf_data;
  logic                  no_alloc;

  logic        misaligned;
  logic        hit;
  logic        beat_ok;
  logic [31:0] hit_word;
  logic [31:0] r_word;
  logic        unused_addr_hi;

  assign misaligned = inst_addr[1:0] != 2'b00;
  assign hit        = LBUF_EN && buf_valid && !fence_i &&
                      (buf_tag == inst_addr[AXI_ADDR_W-1:3]);
  assign hit_word   = inst_addr[2] ? buf_data[63:32] : buf_data[31:0];
  assign r_word     = addr_q[2] ? rdata[63:32] : rdata[31:0];
  assign beat_ok    = rlast && (rid == AXI_ID);
  assign unused_addr_hi = ^inst_addr[63:AXI_ADDR_W];

  assign arvalid   = state == S_AR;
  assign rready    = state == S_R;
  assign if_ready  = state == S_RESP;
  assign araddr    = {addr_q[AXI_ADDR_W-1:3], 3'b000};
  assign arid      = AXI_ID;
  assign arlen     = 8'd0;
  assign arsize    = 3'b011;
  assign arburst   = 2'b01;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      buf_data     <= '0;
      no_alloc     <= 1'b0;
      if_data_read <= '0;
      if_resp_err  <= 1'b0;
    end else begin
      if (fence_i) buf_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_valid) begin
            if (misaligned) begin
              state        <= S_RESP;
              if_data_read <= 64'h13;
              if_resp_err  <= 1'b1;
            end else if (hit) begin
              state        <= S_RESP;
              if_data_read <= {32'h0, hit_word};
              if_resp_err  <= 1'b0;
            end else begin
              state    <= S_AR;
              addr_q   <= inst_addr[AXI_ADDR_W-1:2];
              no_alloc <= 1'b0;
            end
          end
        end
        S_AR: begin
          if (fence_i) no_alloc <= 1'b1;
          if (arready) state <= S_R;
        end
        S_R: begin
          if (fence_i) no_alloc <= 1'b1;
          if (rvalid) begin
            state        <= S_RESP;
            if_data_read <= {32'h0, r_word};
            if_resp_err  <= !beat_ok || (rresp != 2'b00);
            // A fence seen at any point of this read keeps the beat out of the buffer.
            if (LBUF_EN && beat_ok && rresp == 2'b00 && !no_alloc && !fence_i) begin
              buf_valid <= 1'b1;
              buf_tag   <= addr_q[AXI_ADDR_W-1:3];
              buf_data  <= rdata;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_ifu_axi_bridge.sv
`timescale 1ns/1ps
// Bench for the IF AXI bridge: AXI responder with programmable delays, a
// transaction-level line-buffer model, and a per-cycle protocol monitor.
module tb_ysyx_22040759_ifu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [63:0] inst_addr;
  logic        if_ready;
  logic [63:0] if_data_read;
  logic        if_resp_err;
  logic        fence_i;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic [1:0]  dbg_state;

  ysyx_22040759_ifu_axi_bridge dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .inst_addr(inst_addr),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_resp_err(if_resp_err),
    .fence_i(fence_i), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // AXI responder configuration and line-buffer model
  int          ar_delay;
  int          r_delay;
  logic [1:0]  next_rresp;
  bit          bad_rid;
  bit          waiting;
  int          ar_hs_cnt = 0;
  logic [31:0] exp_araddr;
  logic [31:0] sl_addr;
  bit          lb_valid;
  logic [28:0] lb_tag;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_dword(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0297_0010_0073;
    return {a ^ 32'h5EED_1234, (~a) + 32'h0001_3579};
  endfunction

  // AXI slave: programmable AR and R delays
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
    forever begin
      @(negedge clk);
      if (rst_n && arvalid) begin
        sl_addr = araddr;
        repeat (ar_delay) @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        repeat (r_delay) @(negedge clk);
        rvalid = 1'b1; rdata = mem_dword(sl_addr); rresp = next_rresp;
        rlast = 1'b1; rid = bad_rid ? 4'd5 : 4'd0;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rresp = 2'b00;
      end
    end
  end

  // per-cycle protocol monitor
  bit          have_prev = 0;
  logic        p_arvalid, p_arready, p_ready;
  logic [31:0] p_araddr;
  logic [64:0] p_data;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        have_prev = 0;
      end else begin
        if (have_prev && p_arvalid && !p_arready) begin
          check("ar_hold_valid", arvalid, 1);
          check("ar_hold_addr", araddr, p_araddr);
        end
        if (arvalid) begin
          check("araddr", araddr, exp_araddr);
          check("ar_fields", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b011, 2'b01});
        end
        check("data_hi_zero", if_data_read[63:32], 0);
        check("ar_r_exclusive", arvalid && rready, 0);
        if (if_ready) begin
          if (have_prev) check("ready_pulse", p_ready, 0);
          check("ready_while_req", waiting, 1);
        end else if (have_prev) begin
          check("data_hold", {if_resp_err, if_data_read}, p_data);
        end
        if (arvalid && arready) ar_hs_cnt++;
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        p_ready = if_ready; p_data = {if_resp_err, if_data_read};
        have_prev = 1;
      end
    end
  end

  // driver: one fetch, checked against the model; starts and ends on a negedge
  task automatic fetch(input logic [63:0] addr, input bit fence_req, input bit fence_mid,
                       input string name, output logic [63:0] got_data, output logic got_err,
                       output int got_lat, output int got_ar);
    bit          mis, hit, miss, err, fmid;
    logic [63:0] dword, exp_data;
    int          exp_lat, exp_ar, ar0;
    mis   = addr[1:0] != 2'b00;
    hit   = !mis && lb_valid && lb_tag == addr[31:3] && !fence_req;
    miss  = !mis && !hit;
    fmid  = fence_mid && miss;
    if (fence_req) lb_valid = 0;
    dword = mem_dword({addr[31:3], 3'b000});
    exp_data = {32'h0, addr[2] ? dword[63:32] : dword[31:0]};
    if (mis) begin
      exp_data = 64'h13; err = 1; exp_ar = 0; exp_lat = 1;
    end else if (hit) begin
      err = 0; exp_ar = 0; exp_lat = 1;
    end else begin
      err = (next_rresp != 2'b00) || bad_rid;
      exp_ar = 1; exp_lat = 3 + ar_delay + r_delay;
      if (!err && !fmid) begin lb_valid = 1; lb_tag = addr[31:3]; end
      if (fmid) lb_valid = 0;
    end
    exp_q.push_back({63'h0, err});
    exp_q.push_back(exp_data);
    exp_araddr = {addr[31:3], 3'b000};
    ar0 = ar_hs_cnt;
    if_valid = 1'b1; inst_addr = addr; fence_i = fence_req; waiting = 1'b1;
    got_lat = 0;
    forever begin
      @(negedge clk);
      got_lat++;
      fence_i = (got_lat == 1) && fmid;
      if (if_ready) break;
      if (got_lat >= 200) begin
        tests++; fails++;
        $display("FAIL %s_timeout: got no if_ready expected one within 200 cycles", name);
        break;
      end
    end
    got_data = if_data_read; got_err = if_resp_err;
    got_ar = ar_hs_cnt - ar0;
    if_valid = 1'b0; fence_i = 1'b0;
    @(negedge clk);
    waiting = 1'b0;
    got_ar = ar_hs_cnt - ar0;
    check({name, "_err"}, {63'h0, got_err}, exp_q.pop_front());
    check({name, "_data"}, got_data, exp_q.pop_front());
    check({name, "_lat"}, got_lat, exp_lat);
    check({name, "_ar"}, got_ar, exp_ar);
  endtask

  task automatic pulse_fence();
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
    lb_valid = 0;
  endtask

  logic [63:0] d;
  logic        e;
  int          l, n;
  logic [63:0] a;
  bit          seen;

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; inst_addr = '0; fence_i = 1'b0;
    ar_delay = 0; r_delay = 0; next_rresp = 2'b00; bad_rid = 0; waiting = 0;
    lb_valid = 0; lb_tag = '0; exp_araddr = '0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_err", if_resp_err, 0);
    check("rst_data", if_data_read, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // refill then sibling-word hit
    fetch(64'h8000_0000, 0, 0, "t1", d, e, l, n);
    check("t1_lit_data", d, 64'h0010_0073);
    check("t1_lit_lat", l, 3);
    check("t1_lit_ar", n, 1);
    fetch(64'h8000_0004, 0, 0, "t2", d, e, l, n);
    check("t2_lit_data", d, 64'h0000_0297);
    check("t2_lit_lat", l, 1);
    check("t2_lit_ar", n, 0);

    // fence between fetches
    fetch(64'h8000_0004, 0, 0, "t3a", d, e, l, n);
    pulse_fence();
    fetch(64'h8000_0004, 0, 0, "t3b", d, e, l, n);
    check("t3_lit_ar", n, 1);

    // slow arready
    ar_delay = 5;
    fetch(64'h8000_0008, 0, 0, "t4", d, e, l, n);
    check("t4_lit_lat", l, 8);
    ar_delay = 0;

    // AXI error leaves the line unallocated
    next_rresp = 2'b10;
    fetch(64'h8000_0010, 0, 0, "t5a", d, e, l, n);
    check("t5_lit_err", e, 1);
    next_rresp = 2'b00;
    fetch(64'h8000_0014, 0, 0, "t5b", d, e, l, n);
    check("t5_lit_ar", n, 1);

    // bad rid, fence with request, fence during the read
    bad_rid = 1;
    fetch(64'h8000_0018, 0, 0, "rid_err", d, e, l, n);
    check("rid_lit_err", e, 1);
    bad_rid = 0;
    fetch(64'h8000_001c, 0, 0, "rid_refetch", d, e, l, n);
    fetch(64'h8000_0018, 1, 0, "fence_req", d, e, l, n);
    check("fence_req_lit_ar", n, 1);
    fetch(64'h8000_001c, 0, 0, "after_fence_req", d, e, l, n);
    check("after_fence_req_lit_ar", n, 0);
    r_delay = 2;
    fetch(64'h8000_0030, 0, 1, "fence_mid", d, e, l, n);
    r_delay = 0;
    fetch(64'h8000_0034, 0, 0, "after_fence_mid", d, e, l, n);
    check("after_fence_mid_lit_ar", n, 1);

    // misaligned fetch, then reset in the middle of a read
    fetch(64'h8000_0002, 0, 0, "t6", d, e, l, n);
    check("t6_lit_data", d, 64'h13);
    check("t6_lit_err", e, 1);
    r_delay = 8;
    exp_araddr = 32'h8000_0020;
    if_valid = 1'b1; inst_addr = 64'h8000_0020; waiting = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rready) begin seen = 1; break; end
    end
    check("t6_reached_r", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_arvalid", arvalid, 0);
    check("t6_rst_rready", rready, 0);
    check("t6_rst_if_ready", if_ready, 0);
    check("t6_rst_err", if_resp_err, 0);
    check("t6_rst_data", if_data_read, 0);
    if_valid = 1'b0; waiting = 1'b0; lb_valid = 0;
    repeat (12) @(negedge clk);
    rst_n = 1'b1; r_delay = 0;
    @(negedge clk);
    fetch(64'h8000_0000, 0, 0, "post_rst", d, e, l, n);
    check("post_rst_lit_ar", n, 1);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = 64'h8000_0000 + 64'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) a[63:32] = $urandom;
      ar_delay   = $urandom_range(0, 3);
      r_delay    = $urandom_range(0, 3);
      next_rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bad_rid    = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 7) == 0) pulse_fence();
      fetch(a, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, "rand", d, e, l, n);
    end
    bad_rid = 0; next_rresp = 2'b00;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
